// File: rtl/lane_permute_encoder_pkg.sv
// Shared definitions for the lane permute encoder: default geometry, mode and state encodings,
// and small mode-decode helpers.
package lane_permute_encoder_pkg;

  localparam int DEF_DIM      = 5;
  localparam int DEF_LANE_W   = 64;
  localparam int DEF_ROT_STEP = 1;

  typedef enum logic [1:0] {
    MODE_RHO    = 2'b00,
    MODE_PI     = 2'b01,
    MODE_RHOPI  = 2'b10,
    MODE_BYPASS = 2'b11
  } mode_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic mode_has_rho(input mode_t m);
    return (m == MODE_RHO) || (m == MODE_RHOPI);
  endfunction

  function automatic logic mode_has_pi(input mode_t m);
    return (m == MODE_PI) || (m == MODE_RHOPI);
  endfunction

endpackage

// File: rtl/lane_permute_encoder_controller.sv
// Sequencer for the lane permute encoder: start/done handshake, (i,j) lane walk and
// the running rho offset.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | waiting for start; inputs latched on start
//   LOAD    | settle cycle after latching, output untouched
//   RUN     | one lane per cycle, i/j/offset advance
//   DONE    | single-cycle done pulse, back to IDLE
module lane_permute_controller
  import lane_permute_encoder_pkg::*;
#(
  parameter int DIM      = DEF_DIM,
  parameter int LANE_W   = DEF_LANE_W,
  parameter int ROT_STEP = DEF_ROT_STEP,
  localparam int IW      = $clog2(DIM),
  localparam int OW      = $clog2(LANE_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          load,
  output logic          run_en,
  output logic          done,
  output logic          busy,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [OW-1:0] offset
);

  // A step of LANE_W or more is equivalent to its residue; the offset register wraps naturally.
  localparam logic [OW-1:0] STEP = OW'(ROT_STEP % LANE_W);
  localparam logic [IW-1:0] LAST = IW'(DIM - 1);

  logic [1:0] state;
  logic       last_lane;

  assign load      = (state == ST_IDLE) && start;
  assign run_en    = (state == ST_RUN);
  assign last_lane = run_en && (i == LAST) && (j == LAST);
  assign done      = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      i      <= '0;
      j      <= '0;
      offset <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_LOAD;
            i      <= '0;
            j      <= '0;
            offset <= '0;
          end
        end
        ST_LOAD: state <= ST_RUN;
        ST_RUN: begin
          offset <= offset + STEP;
          if (last_lane) begin
            state <= ST_DONE;
          end else if (j == LAST) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lane_permute_encoder.sv
// Lane permute encoder: latches a DIMxDIM lane array and rewrites it one lane per clock
// through rho (rotate), pi (permute), rho+pi or bypass into the output buffer.
module lane_permute_encoder
  import lane_permute_encoder_pkg::*;
#(
  parameter int DIM      = DEF_DIM,
  parameter int LANE_W   = DEF_LANE_W,
  parameter int ROT_STEP = DEF_ROT_STEP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [DIM*DIM*LANE_W-1:0]  data_in,
  output logic                       busy,
  output logic                       done,
  output logic [DIM*DIM*LANE_W-1:0]  data_out
);

  localparam int NB = DIM * DIM * LANE_W;
  localparam int IW = $clog2(DIM);
  localparam int OW = $clog2(LANE_W);
  localparam int LW = $clog2(DIM * DIM);
  localparam int PW = $clog2(5 * DIM);

  logic          load;
  logic          run_en;
  logic [IW-1:0] i;
  logic [IW-1:0] j;
  logic [OW-1:0] offset;

  logic [NB-1:0]       in_buf;
  logic [NB-1:0]       out_buf;
  mode_t               mode_q;
  logic [LW-1:0]       src_lin;
  logic [LW-1:0]       dst_lin;
  logic [LANE_W-1:0]   src;
  logic [LANE_W-1:0]   lane_val;
  logic [2*LANE_W-1:0] rot;
  logic [PW-1:0]       pi_col;

  lane_permute_controller #(
    .DIM      (DIM),
    .LANE_W   (LANE_W),
    .ROT_STEP (ROT_STEP)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .load   (load),
    .run_en (run_en),
    .done   (done),
    .busy   (busy),
    .i      (i),
    .j      (j),
    .offset (offset)
  );

  always_comb begin
    src_lin  = LW'(DIM * int'(i) + int'(j));
    src      = in_buf[src_lin*LANE_W +: LANE_W];
    // Upper half of the doubled lane shifted left is the left rotation; offset 0 yields src.
    rot      = {src, src} << offset;
    lane_val = mode_has_rho(mode_q) ? rot[2*LANE_W-1 -: LANE_W] : src;
    // 2i+3j stays below 5*DIM, so four conditional subtractions replace the modulo.
    pi_col   = PW'(2 * int'(i) + 3 * int'(j));
    for (int n = 0; n < 4; n++) begin
      if (pi_col >= PW'(DIM)) pi_col = pi_col - PW'(DIM);
    end
    dst_lin  = mode_has_pi(mode_q) ? LW'(DIM * int'(j) + int'(pi_col)) : src_lin;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_buf  <= '0;
      out_buf <= '0;
      mode_q  <= MODE_RHO;
    end else begin
      if (load) begin
        in_buf <= data_in;
        mode_q <= mode_t'(mode);
      end
      if (run_en) out_buf[dst_lin*LANE_W +: LANE_W] <= lane_val;
    end
  end

  assign data_out = out_buf;

endmodule

// File: tb/tb_lane_permute_encoder.sv
// Randomised self-checking bench for lane_permute_encoder (DIM=5, LANE_W=8, ROT_STEP=1).
module tb_lane_permute_encoder;

  localparam int DIM  = 5;
  localparam int LW   = 8;
  localparam int STEP = 1;
  localparam int NB   = DIM * DIM * LW;
  localparam int LAT  = 2 + DIM * DIM;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [NB-1:0] data_in;
  logic          busy;
  logic          done;
  logic [NB-1:0] data_out;

  int            n_tests;
  int            n_fail;
  logic [NB-1:0] last_out;

  lane_permute_encoder #(
    .DIM      (DIM),
    .LANE_W   (LW),
    .ROT_STEP (STEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: rotate lane by its linear index (bit at a time), then scatter to the pi target.
  function automatic logic [NB-1:0] model(input logic [1:0] md, input logic [NB-1:0] din);
    logic [NB-1:0] r;
    logic [LW-1:0] s;
    int            off, di, dj;
    bit            rho, pi;
    r   = '0;
    rho = (md == 2'b00) || (md == 2'b10);
    pi  = (md == 2'b01) || (md == 2'b10);
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        s   = din[(DIM*i+j)*LW +: LW];
        off = ((DIM * i + j) * STEP) % LW;
        if (rho) for (int n = 0; n < off; n++) s = {s[LW-2:0], s[LW-1]};
        di  = pi ? j : i;
        dj  = pi ? (2 * i + 3 * j) % DIM : j;
        r[(DIM*di+dj)*LW +: LW] = s;
      end
    end
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] md, input logic [NB-1:0] din,
                        input bit hold);
    logic [NB-1:0] exp;
    int busy_cnt, done_cnt, done_at;
    exp = model(md, din);
    @(negedge clk);
    start   = 1'b1;
    mode    = md;
    data_in = din;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    mode    = ~md;
    data_in = ~din;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, "_load_hold"}, data_out, last_out);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
        chk({tag, "_data_at_done"}, data_out, exp);
        start = 1'b0;
      end
      if (!hold && k == 10) start = 1'b1;
      if (!hold && k == 11) start = 1'b0;
    end
    chk({tag, "_latency"}, done_at, LAT);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_cycles"}, busy_cnt, LAT);
    chk({tag, "_data_out"}, data_out, exp);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    last_out = exp;
  endtask

  function automatic logic [NB-1:0] rand_data();
    logic [NB-1:0] d;
    for (int n = 0; n < DIM * DIM; n++) d[n*LW +: LW] = LW'($urandom);
    return d;
  endfunction

  initial begin
    logic [NB-1:0] d;
    int            flag;
    n_tests  = 0;
    n_fail   = 0;
    last_out = '0;
    rst      = 1'b0;
    start    = 1'b0;
    mode     = 2'b00;
    data_in  = '0;
    #1;
    chk("reset_data_out", data_out, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < DIM * DIM; n++) d[n*LW +: LW] = LW'(n);
    run_op("bypass", 2'b11, d, 1'b0);
    run_op("pi_index", 2'b01, d, 1'b0);

    for (int n = 0; n < DIM * DIM; n++) d[n*LW +: LW] = 8'h01;
    run_op("rho_ones", 2'b00, d, 1'b0);

    d = '0;
    d[6*LW +: LW] = 8'h81;
    run_op("rhopi_single", 2'b10, d, 1'b0);

    run_op("hold_start", 2'b10, rand_data(), 1'b1);

    for (int t = 0; t < 8; t++) begin
      run_op($sformatf("rand%0d", t), 2'($urandom_range(0, 3)), rand_data(), t[0]);
    end

    // Abort at RUN cycle 10 with a nonzero previous result still in the buffer.
    @(negedge clk);
    start   = 1'b1;
    mode    = 2'b00;
    data_in = rand_data();
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_data_out", data_out, '0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    flag = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) flag = 1;
    end
    chk("abort_quiet", flag, 0);
    rst      = 1'b1;
    last_out = '0;
    run_op("after_abort", 2'b10, rand_data(), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
